// File: rtl/sys1_video_pkg.sv
// Shared constants and helpers for the System 1 raster timing generator.
package sys1_video_pkg;

  // Counter and offset widths
  localparam int CNT_W = 9;   // PH / PV width
  localparam int OFS_W = 4;   // signed HOFS / VOFS width
  localparam int SUM_W = 10;  // signed width for start + offset
  localparam int EXT_W = 11;  // unsigned width for window end (start + width)

  // Default timing (6 MHz pixel from 48 MHz, 384 x 262 raster)
  localparam int DEF_CLK_DIV  = 8;
  localparam int DEF_H_TOTAL  = 384;
  localparam int DEF_H_ACTIVE = 256;
  localparam int DEF_HS_START = 296;
  localparam int DEF_HS_WIDTH = 32;
  localparam int DEF_V_TOTAL  = 262;
  localparam int DEF_V_ACTIVE = 224;
  localparam int DEF_VS_START = 240;
  localparam int DEF_VS_WIDTH = 3;

  // Nominal start plus signed offset, folded back into 0..total-1.
  // The offset is at most +/-8, so a single add or subtract of total suffices.
  function automatic logic [EXT_W-1:0] wrap_start(
    input int               start,
    input logic [OFS_W-1:0] ofs,
    input int               total
  );
    logic signed [SUM_W-1:0] ofs_s;
    logic signed [SUM_W-1:0] sum;
    logic signed [SUM_W-1:0] tot;
    ofs_s = {{(SUM_W-OFS_W){ofs[OFS_W-1]}}, ofs};
    tot   = SUM_W'(total);
    sum   = SUM_W'(start) + ofs_s;
    if (sum[SUM_W-1]) begin
      sum = sum + tot;
    end else if (sum >= tot) begin
      sum = sum - tot;
    end
    return {{(EXT_W-SUM_W){1'b0}}, sum};
  endfunction

endpackage

// File: rtl/sys1_video_if.sv
// Raster timing bundle: offsets in, pixel clocking / counters / blank / sync out.
interface sys1_video_if;
  import sys1_video_pkg::*;

  logic [OFS_W-1:0] HOFS;
  logic [OFS_W-1:0] VOFS;
  logic             PCE;
  logic             PCLK;
  logic [CNT_W-1:0] PH;
  logic [CNT_W-1:0] PV;
  logic             HBLK;
  logic             VBLK;
  logic             HSYNC;
  logic             VSYNC;
  logic             FRAME;

  // Timing generator side
  modport master (
    input  HOFS, VOFS,
    output PCE, PCLK, PH, PV, HBLK, VBLK, HSYNC, VSYNC, FRAME
  );

  // Consumer side (video / main blocks)
  modport slave (
    output HOFS, VOFS,
    input  PCE, PCLK, PH, PV, HBLK, VBLK, HSYNC, VSYNC, FRAME
  );

endinterface

// File: rtl/sys1_sync_window.sv
// Sync window decode: hit while cnt lies in [start+ofs, start+ofs+WIDTH) modulo TOTAL.
// Windows that run past TOTAL-1 continue from 0.
module sys1_sync_window
  import sys1_video_pkg::*;
#(
  parameter int TOTAL = DEF_H_TOTAL,
  parameter int START = DEF_HS_START,
  parameter int WIDTH = DEF_HS_WIDTH
) (
  input  logic [CNT_W-1:0] cnt_i,
  input  logic [OFS_W-1:0] ofs_i,
  output logic             hit_o
);

  localparam logic [EXT_W-1:0] TOTAL_E = EXT_W'(TOTAL);
  localparam logic [EXT_W-1:0] WIDTH_E = EXT_W'(WIDTH);

  logic [EXT_W-1:0] start_e;
  logic [EXT_W-1:0] stop_e;
  logic [EXT_W-1:0] cnt_e;
  logic             in_main;
  logic             in_wrap;

  // Window compare, including the part that wrapped past the end of the line/frame
  always_comb begin
    start_e = wrap_start(START, ofs_i, TOTAL);
    stop_e  = start_e + WIDTH_E;
    cnt_e   = {{(EXT_W-CNT_W){1'b0}}, cnt_i};
    in_main = (cnt_e >= start_e) && (cnt_e < stop_e);
    in_wrap = (stop_e > TOTAL_E) && (cnt_e < (stop_e - TOTAL_E));
    hit_o   = in_main || in_wrap;
  end

endmodule

// File: rtl/sys1_video_timing.sv
// System 1 raster timing: pixel clock-enable / square clock from clk48M,
// PH/PV counters, blanking, offset-adjustable sync and a frame-start pulse.
module sys1_video_timing
  import sys1_video_pkg::*;
#(
  parameter int CLK_DIV  = DEF_CLK_DIV,
  parameter int H_TOTAL  = DEF_H_TOTAL,
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int HS_START = DEF_HS_START,
  parameter int HS_WIDTH = DEF_HS_WIDTH,
  parameter int V_TOTAL  = DEF_V_TOTAL,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int VS_START = DEF_VS_START,
  parameter int VS_WIDTH = DEF_VS_WIDTH
) (
  input  logic         clk48M,
  input  logic         reset_n,
  sys1_video_if.master vid
);

  localparam int               DIV_W    = $clog2(CLK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);

  // State
  logic [DIV_W-1:0] div_q,  div_d;
  logic             pce_q,  pce_d;
  logic             pclk_q, pclk_d;
  logic [CNT_W-1:0] ph_q,   ph_d;
  logic [CNT_W-1:0] pv_q,   pv_d;
  logic             hblk_q, hblk_d;
  logic             vblk_q, vblk_d;
  logic             hsync_q, hsync_d;
  logic             vsync_q, vsync_d;
  logic             frame_q, frame_d;
  logic [OFS_W-1:0] hofs_q, hofs_d;
  logic [OFS_W-1:0] vofs_q, vofs_d;

  // Decode helpers
  logic line_wrap;
  logic ofs_load;
  logic hs_hit;
  logic vs_hit;

  // Sync windows look at the next counter values and next offsets so the
  // registered sync lines up with the PH/PV shown on the same cycle.
  sys1_sync_window #(
    .TOTAL (H_TOTAL),
    .START (HS_START),
    .WIDTH (HS_WIDTH)
  ) u_hwin (
    .cnt_i (ph_d),
    .ofs_i (hofs_d),
    .hit_o (hs_hit)
  );

  sys1_sync_window #(
    .TOTAL (V_TOTAL),
    .START (VS_START),
    .WIDTH (VS_WIDTH)
  ) u_vwin (
    .cnt_i (pv_d),
    .ofs_i (vofs_d),
    .hit_o (vs_hit)
  );

  // Next-state: divider, pixel counters, offset latch and derived flags
  always_comb begin
    div_d  = div_q + DIV_W'(1);
    pce_d  = (div_d == DIV_LAST);
    pclk_d = div_d[DIV_W-1];

    ph_d      = ph_q;
    pv_d      = pv_q;
    line_wrap = pce_q && (ph_q == H_LAST);
    if (pce_q) begin
      if (line_wrap) begin
        ph_d = '0;
        pv_d = (pv_q == V_LAST) ? '0 : pv_q + CNT_W'(1);
      end else begin
        ph_d = ph_q + CNT_W'(1);
      end
    end

    // Offsets only change at the start of vertical blank, so sync never tears
    ofs_load = line_wrap && (pv_d == V_ACT);
    hofs_d   = ofs_load ? vid.HOFS : hofs_q;
    vofs_d   = ofs_load ? vid.VOFS : vofs_q;

    // Derived outputs move only on pixel edges, together with PH/PV
    hblk_d  = pce_q ? (ph_d >= H_ACT) : hblk_q;
    vblk_d  = pce_q ? (pv_d >= V_ACT) : vblk_q;
    hsync_d = pce_q ? hs_hit : hsync_q;
    vsync_d = pce_q ? vs_hit : vsync_q;
    frame_d = line_wrap && (pv_d == '0);
  end

  // State registers; reset asserts asynchronously and returns everything to idle
  always_ff @(posedge clk48M or negedge reset_n) begin
    if (!reset_n) begin
      div_q   <= '0;
      pce_q   <= 1'b0;
      pclk_q  <= 1'b0;
      ph_q    <= '0;
      pv_q    <= '0;
      hblk_q  <= 1'b0;
      vblk_q  <= 1'b0;
      hsync_q <= 1'b0;
      vsync_q <= 1'b0;
      frame_q <= 1'b0;
      hofs_q  <= '0;
      vofs_q  <= '0;
    end else begin
      div_q   <= div_d;
      pce_q   <= pce_d;
      pclk_q  <= pclk_d;
      ph_q    <= ph_d;
      pv_q    <= pv_d;
      hblk_q  <= hblk_d;
      vblk_q  <= vblk_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      frame_q <= frame_d;
      hofs_q  <= hofs_d;
      vofs_q  <= vofs_d;
    end
  end

  assign vid.PCE   = pce_q;
  assign vid.PCLK  = pclk_q;
  assign vid.PH    = ph_q;
  assign vid.PV    = pv_q;
  assign vid.HBLK  = hblk_q;
  assign vid.VBLK  = vblk_q;
  assign vid.HSYNC = hsync_q;
  assign vid.VSYNC = vsync_q;
  assign vid.FRAME = frame_q;

endmodule
